ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter RR_EN, default 1: 1 = round-robin between ports; 0 = data port always has priority.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 inst_req  input  1  instruction-fetch read request; held until granted.
REQ-005 inst_addr  input  32  fetch byte address; bits [1:0] ignored.
REQ-006 inst_gnt  output  1  fetch request accepted this cycle (combinational).
REQ-007 inst_rvalid / inst_rdata  output  1 / 32  fetch word returned.
REQ-008 data_req / data_we  input  1 / 1  data request held until granted / 1 = store.
REQ-009 data_size  input  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
REQ-010 data_unsigned  input  1  load extension select: 1 = zero-extend, 0 = sign-extend.
REQ-011 data_addr / data_wdata  input  32 / 32  data byte address / store data, right-aligned.
REQ-012 data_gnt  output  1  data request accepted this cycle (combinational).
REQ-013 data_rvalid / data_rdata / data_err  output  1 / 32 / 1  load result / misaligned-access flag.
REQ-014 ram_ena / ram_wea / ram_addra / ram_dina  output  1 / 4 / 32 / 32  single-port block RAM controls.
REQ-015 ram_douta  input  32  RAM read data; valid one cycle after the issuing edge.

Function
REQ-016 RAM addressing: the RAM is word-addressed, so ram_addra SHALL be {2'b00, addr[31:2]}; byte lanes are little-endian, with lane k at bits [8k+7:8k].
REQ-017 At most one grant SHALL be issued per cycle; a grant SHALL be possible every cycle, with no bubbles between back-to-back grants.
REQ-018 Arbitration:
- If only one port requests, that port SHALL be granted.
- If both ports request and RR_EN = 0, the data port SHALL be granted.
- If both ports request and RR_EN = 1, the port not granted most recently SHALL be granted.
REQ-019 Grant cycle: ram_ena, ram_wea, ram_addra and ram_dina SHALL be driven combinationally for the granted port; with no grant, ram_ena = 0 and ram_wea = 0.
REQ-020 Fetch: the grant SHALL issue a read with wea = 0; one cycle later, inst_rvalid = 1 and inst_rdata = ram_douta.
REQ-021 Store byte enables:
- Byte: wea = 4'b0001 << addr[1:0], with the byte replicated to all lanes.
- Half: wea = 4'b0011 << addr[1:0], with the half replicated to both halves.
- Word: wea = 4'b1111.
REQ-022 A store SHALL produce no rvalid.
REQ-023 Load return: one cycle after the grant, data_rvalid = 1, and data_rdata = the lane selected by the registered addr[1:0] and size, zero- or sign-extended per the registered data_unsigned.
REQ-024 Misaligned access (half with addr[0] = 1, or word with addr[1:0] != 0): data_gnt = 1, ram_ena = 0, and no RAM write; the next cycle data_err = 1 for one cycle and data_rvalid = 0.
REQ-025 Pending-return state SHALL be registered: valid, port, size, lane, unsigned flag and err.
- A new grant in the return cycle SHALL NOT disturb the return in progress.
REQ-026 rvalid and data_err SHALL be single-cycle pulses; rdata SHALL hold its last value when rvalid = 0.
REQ-027 Round-robin pointer: updated only on a grant; simultaneous requests under RR_EN = 1 SHALL alternate on every granted cycle.
REQ-028 Requesters SHALL keep address and data stable while req = 1 and gnt = 0; gnt = 1 completes the request in that cycle.

Reset
REQ-029 While rst = 1:
- All rvalid/err = 0, rdata = 0, pending valid = 0, and ram_ena/ram_wea = 0.
- Round-robin pointer favours the data port next.
REQ-030 A read granted in the cycle before reset asserts SHALL produce no rvalid after reset.
REQ-031 The first grant is possible in the first cycle after rst deasserts.

Verification
REQ-032 Store word 0x11223344 to 0x0, then load word from 0x0 -> data_rvalid 1 cycle after grant, data_rdata = 0x11223344.
REQ-033 Store byte 0xAA to 0x1, then signed byte load from 0x1, then unsigned byte load from 0x1:
- Store: ram_wea = 4'b0010.
- Signed load: data_rdata = 0xFFFFFFAA.
- Unsigned load: data_rdata = 0x000000AA.
REQ-034 Signed half load from 0x2 over word 0x80013344 -> data_rdata = 0xFFFF8001; store half to 0x2 -> ram_wea = 4'b1100.
REQ-035 Both ports request continuously for 4 cycles, RR_EN = 1:
- Grants SHALL be data, inst, data, inst.
- Each returns the correct word one cycle later, with no lost returns.
REQ-036 Word load from 0x6 -> data_gnt = 1, ram_ena = 0, data_err pulse next cycle, RAM contents unchanged.
REQ-037 Assert rst in the cycle after an inst grant -> inst_rvalid stays 0; normal grants resume after rst deasserts.

Source files
------------

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arbiter
//  Purpose  : Shares one single-port block RAM between an instruction-fetch
//             port (word reads) and a data port (byte/half/word loads and
//             stores). One grant per cycle, no bubbles; returns arrive one
//             cycle after the grant.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    RR_EN          1 = round-robin on contention, 0 = data port always wins
//  Ports
//    clk, rst       clock, asynchronous active-high reset
//    inst_req/addr  fetch request (held until granted), byte address
//    inst_gnt       fetch accepted this cycle (combinational)
//    inst_rvalid    fetch word returned on inst_rdata
//    data_req/we    data request (held until granted), 1 = store
//    data_size      0 byte, 1 half, 2/3 word
//    data_unsigned  load zero-extend (1) or sign-extend (0)
//    data_addr      data byte address
//    data_wdata     store data, right-aligned
//    data_gnt       data request accepted this cycle (combinational)
//    data_rvalid    load result on data_rdata
//    data_err       one-cycle pulse for a misaligned access
//    ram_*          block RAM port A controls; ram_douta is valid one
//                   cycle after the issuing edge
// ============================================================================
module ram_arbiter #(
  parameter int RR_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_gnt,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [1:0]  data_size,
  input  logic        data_unsigned,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        data_err,
  output logic        ram_ena,
  output logic [3:0]  ram_wea,
  output logic [31:0] ram_addra,
  output logic [31:0] ram_dina,
  input  logic [31:0] ram_douta
);

  // Arbitration and pending-return state
  logic        r_prio_data;   // 1: data port wins the next contended cycle
  logic        r_pend_valid;
  logic        r_pend_data;   // 1: pending return belongs to the data port
  logic        r_pend_err;
  logic [1:0]  r_pend_size;
  logic [1:0]  r_pend_lane;
  logic        r_pend_uns;
  logic [31:0] r_inst_rdata;  // last delivered words, held between returns
  logic [31:0] r_data_rdata;

  logic [1:0]  w_size;
  logic        w_misaligned;
  logic        w_data_win;
  logic        w_data_ok;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shift;
  logic [31:0] w_load;
  logic        w_unused;

  // Fetches are always whole words; the low address bits carry no meaning.
  assign w_unused = ^inst_addr[1:0];

  assign w_size       = (data_size == 2'd3) ? 2'd2 : data_size;
  assign w_misaligned = ((w_size == 2'd1) && data_addr[0]) ||
                        ((w_size == 2'd2) && (data_addr[1:0] != 2'b00));

  // Grants are combinational; reset suppresses them so the RAM stays idle.
  assign w_data_win = (RR_EN != 0) ? (!inst_req || r_prio_data) : 1'b1;
  assign data_gnt   = !rst && data_req && w_data_win;
  assign inst_gnt   = !rst && inst_req && !data_gnt;

  // A misaligned data access is accepted but never reaches the RAM.
  assign w_data_ok  = data_gnt && !w_misaligned;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = data_wdata;
    case (w_size)
      2'd0: begin
        w_be    = 4'b0001 << data_addr[1:0];
        w_wdata = {4{data_wdata[7:0]}};
      end
      2'd1: begin
        w_be    = 4'b0011 << data_addr[1:0];
        w_wdata = {2{data_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = data_wdata;
      end
    endcase
  end

  assign ram_ena   = inst_gnt || w_data_ok;
  assign ram_wea   = (w_data_ok && data_we) ? w_be : 4'b0000;
  assign ram_addra = {2'b00, (inst_gnt ? inst_addr[31:2] : data_addr[31:2])};
  assign ram_dina  = w_wdata;

  // Load alignment: bring the addressed lane down to bit 0, then extend.
  assign w_shift = ram_douta >> {r_pend_lane, 3'b000};

  always_comb begin
    w_load = w_shift;
    case (r_pend_size)
      2'd0:    w_load = r_pend_uns ? {24'h000000, w_shift[7:0]}
                                   : {{24{w_shift[7]}}, w_shift[7:0]};
      2'd1:    w_load = r_pend_uns ? {16'h0000, w_shift[15:0]}
                                   : {{16{w_shift[15]}}, w_shift[15:0]};
      default: w_load = w_shift;
    endcase
  end

  assign inst_rvalid = r_pend_valid && !r_pend_data;
  assign data_rvalid = r_pend_valid && r_pend_data;
  assign data_err    = r_pend_err;
  assign inst_rdata  = inst_rvalid ? ram_douta : r_inst_rdata;
  assign data_rdata  = data_rvalid ? w_load    : r_data_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio_data  <= 1'b1;
      r_pend_valid <= 1'b0;
      r_pend_data  <= 1'b0;
      r_pend_err   <= 1'b0;
      r_pend_size  <= 2'd0;
      r_pend_lane  <= 2'd0;
      r_pend_uns   <= 1'b0;
      r_inst_rdata <= 32'h0;
      r_data_rdata <= 32'h0;
    end else begin
      // The port just served loses the next contended cycle.
      if (inst_gnt || data_gnt) begin
        r_prio_data <= inst_gnt;
      end
      r_pend_valid <= inst_gnt || (w_data_ok && !data_we);
      r_pend_data  <= data_gnt;
      r_pend_err   <= data_gnt && w_misaligned;
      if (data_gnt) begin
        r_pend_size <= w_size;
        r_pend_lane <= data_addr[1:0];
        r_pend_uns  <= data_unsigned;
      end
      if (inst_rvalid) begin
        r_inst_rdata <= ram_douta;
      end
      if (data_rvalid) begin
        r_data_rdata <= w_load;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_arbiter
//  Purpose  : Self-checking bench for ram_arbiter (RR_EN = 1). A block RAM
//             model answers the RAM port; a byte-array reference memory and
//             simple arbitration rules predict grants, RAM controls and
//             returned data.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = 32'h0;
  logic        inst_gnt, inst_rvalid;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0, data_we = 1'b0, data_unsigned = 1'b0;
  logic [1:0]  data_size = 2'd0;
  logic [31:0] data_addr = 32'h0, data_wdata = 32'h0;
  logic        data_gnt, data_rvalid, data_err;
  logic [31:0] data_rdata;
  logic        ram_ena;
  logic [3:0]  ram_wea;
  logic [31:0] ram_addra, ram_dina, ram_douta;

  ram_arbiter #(.RR_EN(1)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_we(data_we), .data_size(data_size),
    .data_unsigned(data_unsigned), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .data_rdata(data_rdata), .data_err(data_err),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra),
    .ram_dina(ram_dina), .ram_douta(ram_douta)
  );

  always #5 clk = ~clk;

  // Block RAM: 64 words, read-first, byte-lane write enables.
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (ram_ena) begin
      for (int k = 0; k < 4; k++)
        if (ram_wea[k]) mem[ram_addra[5:0]][8*k +: 8] <= ram_dina[8*k +: 8];
      ram_douta <= mem[ram_addra[5:0]];
    end
  end

  // Reference model
  logic [7:0]  ref_mem [0:255];
  bit          m_prio_data;
  logic [31:0] last_ird, last_drd;
  logic        last_gi, last_gd, last_ena;
  logic [3:0]  last_wea;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] load_val(input logic [31:0] a, input logic [1:0] sz,
                                           input logic uns);
    logic [31:0] v;
    int n;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    v = 32'h0;
    for (int k = n - 1; k >= 0; k--) v = (v << 8) | 32'(ref_mem[int'(a[7:0]) + k]);
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
    return v;
  endfunction

  task automatic set_d(input logic req, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] wd);
    data_req = req; data_we = we; data_size = sz; data_unsigned = uns;
    data_addr = a; data_wdata = wd;
  endtask

  task automatic set_i(input logic req, input logic [31:0] a);
    inst_req = req; inst_addr = a;
  endtask

  // Called at posedge+1 with inputs applied; returns at the next posedge+1.
  task automatic do_cycle(input bit rst_at_edge);
    bit gi, gd, mis, n_iv, n_dv, n_err;
    int n;
    logic [1:0]  sz;
    logic [3:0]  e_wea;
    logic [31:0] e_dina, mask, n_ird, n_drd;
    #3;
    gd  = data_req && (!inst_req || m_prio_data);
    gi  = inst_req && !gd;
    sz  = (data_size == 2'd3) ? 2'd2 : data_size;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mis = gd && (data_addr[1:0] % n != 0);
    e_wea = 4'b0; e_dina = 32'h0; mask = 32'h0;
    if (gd && !mis && data_we)
      for (int k = 0; k < n; k++) begin
        e_wea[data_addr[1:0] + k] = 1'b1;
        e_dina[8*(data_addr[1:0] + k) +: 8] = data_wdata[8*k +: 8];
        mask[8*(data_addr[1:0] + k) +: 8] = 8'hFF;
      end
    last_gi = inst_gnt; last_gd = data_gnt; last_ena = ram_ena; last_wea = ram_wea;
    chk("inst_gnt", inst_gnt, gi);
    chk("data_gnt", data_gnt, gd);
    chk("ram_ena", ram_ena, gi || (gd && !mis));
    chk("ram_wea", ram_wea, e_wea);
    if (gi || (gd && !mis))
      chk("ram_addra", ram_addra, {2'b00, (gi ? inst_addr[31:2] : data_addr[31:2])});
    if (e_wea != 4'b0) chk("ram_dina", ram_dina & mask, e_dina);
    n_iv  = gi;
    n_ird = load_val({inst_addr[31:2], 2'b00}, 2'd2, 1'b1);
    n_dv  = gd && !mis && !data_we;
    n_drd = load_val(data_addr, sz, data_unsigned);
    n_err = mis;
    if (gd && !mis && data_we)
      for (int k = 0; k < n; k++) ref_mem[int'(data_addr[7:0]) + k] = data_wdata[8*k +: 8];
    if (gi || gd) m_prio_data = gi;
    @(posedge clk);
    if (rst_at_edge) begin
      rst = 1'b1;
      n_iv = 0; n_dv = 0; n_err = 0;
      last_ird = 32'h0; last_drd = 32'h0; m_prio_data = 1'b1;
    end
    #1;
    chk("inst_rvalid", inst_rvalid, n_iv);
    chk("data_rvalid", data_rvalid, n_dv);
    chk("data_err", data_err, n_err);
    if (n_iv) last_ird = n_ird;
    if (n_dv) last_drd = n_drd;
    chk("inst_rdata", inst_rdata, last_ird);
    chk("data_rdata", data_rdata, last_drd);
  endtask

  // Called at posedge+1; holds reset two cycles and releases at posedge+1.
  task automatic apply_reset();
    rst = 1'b1;
    #2;
    chk("rst_inst_rvalid", inst_rvalid, 0);
    chk("rst_data_rvalid", data_rvalid, 0);
    chk("rst_data_err", data_err, 0);
    chk("rst_inst_rdata", inst_rdata, 0);
    chk("rst_data_rdata", data_rdata, 0);
    chk("rst_ram_ena", ram_ena, 0);
    chk("rst_ram_wea", ram_wea, 0);
    chk("rst_gnts", {inst_gnt, data_gnt}, 0);
    @(posedge clk); @(posedge clk); #1;
    chk("rst_inst_rvalid_hold", inst_rvalid, 0);
    rst = 1'b0;
    m_prio_data = 1'b1; last_ird = 32'h0; last_drd = 32'h0;
  endtask

  initial begin
    logic [31:0] r, a;
    @(posedge clk); #1;
    apply_reset();

    // Fill every RAM word through the data port.
    for (int i = 0; i < 64; i++) begin
      r = $urandom;
      a = {r[31:8], 6'(i), 2'b00};
      set_d(1, 1, 2'd2, 0, a, $urandom);
      do_cycle(0);
    end

    // Word store then word load.
    set_d(1, 1, 2'd2, 0, 32'h0, 32'h11223344); do_cycle(0);
    set_d(1, 0, 2'd2, 0, 32'h0, 32'h0);        do_cycle(0);
    chk("ld_word", data_rdata, 32'h11223344);

    // Byte store, signed and unsigned byte loads.
    set_d(1, 1, 2'd0, 0, 32'h1, 32'h000000AA); do_cycle(0);
    chk("st_byte_wea", last_wea, 4'b0010);
    set_d(1, 0, 2'd0, 0, 32'h1, 32'h0);        do_cycle(0);
    chk("ld_byte_s", data_rdata, 32'hFFFFFFAA);
    set_d(1, 0, 2'd0, 1, 32'h1, 32'h0);        do_cycle(0);
    chk("ld_byte_u", data_rdata, 32'h000000AA);

    // Signed half load from the upper half, then half store there.
    set_d(1, 1, 2'd2, 0, 32'h0, 32'h80013344); do_cycle(0);
    set_d(1, 0, 2'd1, 0, 32'h2, 32'h0);        do_cycle(0);
    chk("ld_half_s", data_rdata, 32'hFFFF8001);
    set_d(1, 1, 2'd1, 0, 32'h2, 32'h00005566); do_cycle(0);
    chk("st_half_wea", last_wea, 4'b1100);
    set_d(1, 0, 2'd3, 0, 32'h0, 32'h0);        do_cycle(0);
    chk("ld_word_after_half", data_rdata, 32'h55663344);

    // Misaligned word load: accepted, no RAM access, error pulse.
    set_d(1, 0, 2'd2, 0, 32'h6, 32'h0);        do_cycle(0);
    chk("mis_gnt", last_gd, 1);
    chk("mis_ena", last_ena, 0);
    chk("mis_err", data_err, 1);
    set_d(1, 1, 2'd2, 0, 32'h6, 32'hDEADBEEF); do_cycle(0);
    chk("mis_st_wea", last_wea, 4'b0000);
    set_d(1, 0, 2'd2, 0, 32'h4, 32'h0);        do_cycle(0);

    // Fetch granted, reset asserted in its return cycle.
    set_d(0, 0, 2'd0, 0, 32'h0, 32'h0);
    set_i(1, 32'h8);
    do_cycle(1);
    apply_reset();

    // Both ports request continuously right after reset.
    set_i(1, 32'h10);
    set_d(1, 0, 2'd2, 0, 32'h20, 32'h0);
    for (int c = 0; c < 4; c++) begin
      do_cycle(0);
      chk("rr_data_gnt", last_gd, (c % 2 == 0) ? 1 : 0);
      chk("rr_inst_gnt", last_gi, (c % 2 == 1) ? 1 : 0);
    end

    // Random traffic; an ungranted request is held unchanged.
    last_gi = 1; last_gd = 1;
    for (int c = 0; c < 400; c++) begin
      if (!inst_req || last_gi) begin
        r = $urandom; a = $urandom;
        set_i(r[1:0] != 2'b00, a);
      end
      if (!data_req || last_gd) begin
        r = $urandom; a = $urandom;
        set_d(r[1:0] != 2'b00, r[2], r[4:3], r[5], a, $urandom);
      end
      do_cycle(0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
